// File: rtl/cache_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | cache_arbiter_pkg : shared types and widths for the I/D-cache arbiter      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_arbiter_pkg;

  localparam int C_ADDR_W = 32;
  localparam int C_LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } arb_owner_t;

  function automatic arb_state_t owner_state(input arb_owner_t owner);
    if (owner == OWN_DCACHE) begin
      return ARB_DCACHE;
    end
    return ARB_ICACHE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | cache_arbiter_if : cache-side and memory-side line port signals            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cache_arbiter_if
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int LINE_W = C_LINE_W
);

  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter view
  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // Environment view: both caches plus the cacheline adaptor
  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

`default_nettype wire

// File: rtl/cache_arbiter_select.sv
// +----------------------------------------------------------------------------+
// | cache_arb_select : combinational winner picker (D-cache priority, or       |
// | round-robin tie-break when CACHE_ARB_RR_EN is defined)                     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_arb_select
  import cache_arbiter_pkg::*;
(
  input  logic       i_icache_req,
  input  logic       i_dcache_req,
  input  arb_owner_t i_last_owner,
  output arb_owner_t o_grant
);

  always_comb begin
    o_grant = OWN_DCACHE;
    if (i_icache_req && !i_dcache_req) begin
      o_grant = OWN_ICACHE;
    end else if (i_icache_req && i_dcache_req) begin
`ifdef CACHE_ARB_RR_EN
      if (i_last_owner == OWN_ICACHE) begin
        o_grant = OWN_DCACHE;
      end else begin
        o_grant = OWN_ICACHE;
      end
`else
      // A data miss freezes the whole pipeline, so D wins every tie
      o_grant = OWN_DCACHE;
`endif
    end
  end

`ifndef CACHE_ARB_RR_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
`endif

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// +----------------------------------------------------------------------------+
// | cache_arbiter : serialises I/D-cache line transactions onto one memory     |
// | port; optional round-robin tie-break via macro CACHE_ARB_RR_EN             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int LINE_W = C_LINE_W
)(
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.slave  io_bus
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  arb_owner_t        w_grant;
  arb_owner_t        w_last_owner;
  logic              w_icache_req;
  logic              w_dcache_req;
  logic              w_any_req;
  logic              w_grant_now;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_icache_resp;
  logic              w_dcache_resp;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;

  assign w_icache_req = io_bus.icache_pmem_read;
  assign w_dcache_req = io_bus.dcache_pmem_read | io_bus.dcache_pmem_write;
  assign w_any_req    = w_icache_req | w_dcache_req;
  assign w_grant_now  = (r_state == ARB_IDLE) && w_any_req;

  cache_arb_select u_select (
    .i_icache_req (w_icache_req),
    .i_dcache_req (w_dcache_req),
    .i_last_owner (w_last_owner),
    .o_grant      (w_grant)
  );

`ifdef CACHE_ARB_RR_EN
  arb_owner_t r_last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWN_ICACHE;
    end else if (w_grant_now) begin
      r_last_owner <= w_grant;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_ICACHE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_icache_resp = 1'b0;
    w_dcache_resp = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_next_state = owner_state(w_grant);
        end
      end
      ARB_ICACHE: begin
        w_mem_read  = ~r_is_write;
        w_mem_write = r_is_write;
        if (io_bus.mem_resp) begin
          w_icache_resp = 1'b1;
          w_next_state  = ARB_IDLE;
        end
      end
      ARB_DCACHE: begin
        w_mem_read  = ~r_is_write;
        w_mem_write = r_is_write;
        if (io_bus.mem_resp) begin
          w_dcache_resp = 1'b1;
          w_next_state  = ARB_IDLE;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Address, op and write data are captured only at grant, so requester changes later are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write    <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else if (w_grant_now) begin
      if (w_grant == OWN_DCACHE) begin
        r_is_write    <= io_bus.dcache_pmem_write;
        r_mem_address <= io_bus.dcache_pmem_address;
        if (io_bus.dcache_pmem_write) begin
          r_mem_wdata <= io_bus.dcache_pmem_wdata;
        end
      end else begin
        r_is_write    <= 1'b0;
        r_mem_address <= io_bus.icache_pmem_address;
      end
    end
  end

  assign io_bus.mem_read          = w_mem_read;
  assign io_bus.mem_write         = w_mem_write;
  assign io_bus.mem_address       = r_mem_address;
  assign io_bus.mem_wdata         = r_mem_wdata;
  assign io_bus.icache_pmem_resp  = w_icache_resp;
  assign io_bus.dcache_pmem_resp  = w_dcache_resp;
  assign io_bus.icache_pmem_rdata = io_bus.mem_rdata;
  assign io_bus.dcache_pmem_rdata = io_bus.mem_rdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(io_bus.dcache_pmem_read && io_bus.dcache_pmem_write))
        else $error("cache_arbiter: dcache read and write asserted together");
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache and the D-cache miss paths of the pipelined rv32i core.
- Sits between both caches and the cacheline adaptor.
- Serialises one line transaction at a time, latches the winner's address and write data, and routes the response back to that owner only.
- Each cache's stall, and therefore the hazard unit's inst_resp/data_resp inputs, depends on this block's resp timing.

Parameters:
- ADDR_W, 32, physical line address width.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_pmem_read  in  1  I-cache line fill request.
- icache_pmem_address  in  ADDR_W  I-cache line address.
- icache_pmem_rdata  out  LINE_W  fill data to I-cache.
- icache_pmem_resp  out  1  one-cycle completion to I-cache.
- dcache_pmem_read  in  1  D-cache line fill request.
- dcache_pmem_write  in  1  D-cache writeback request.
- dcache_pmem_address  in  ADDR_W  D-cache line address.
- dcache_pmem_wdata  in  LINE_W  writeback data.
- dcache_pmem_rdata  out  LINE_W  fill data to D-cache.
- dcache_pmem_resp  out  1  one-cycle completion to D-cache.
- mem_read  out  1  line read to adaptor.
- mem_write  out  1  line write to adaptor.
- mem_address  out  ADDR_W  latched address.
- mem_wdata  out  LINE_W  latched write data.
- mem_rdata  in  LINE_W  line from adaptor.
- mem_resp  in  1  adaptor completion, one cycle.

Behaviour:
- States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE. Reset (rst=1 at an edge) forces ARB_IDLE.
- Reset values:
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
  - Both resp outputs 0.
  - Round-robin pointer (optional feature) = ICACHE.
- ARB_IDLE:
  - mem_read/mem_write deasserted.
  - If any request is asserted, pick a winner (rule below).
  - Latch its address, and its wdata for a D-cache write; mem_wdata is otherwise unchanged.
  - Latch the op: read, or write for a D-cache write.
  - Move to ARB_ICACHE or ARB_DCACHE.
  - mem_read/mem_write assert the cycle after the request is first seen, giving 1 cycle of arbitration latency.
- ARB_ICACHE / ARB_DCACHE:
  - Drive the latched mem_read or mem_write and the latched address/wdata.
  - These stay stable until mem_resp, independent of requester inputs.
  - In the cycle mem_resp=1, the owner's *_pmem_resp=1 combinationally; the other cache's resp stays 0.
  - Next state is ARB_IDLE, so at least one idle cycle separates back-to-back grants. Requesters drop their request after seeing resp.
- rdata: mem_rdata is broadcast unmodified to both icache_pmem_rdata and dcache_pmem_rdata. Only resp is gated.
- Default priority (feature off): the D-cache wins every tie, because a data miss freezes the whole pipeline.
- Boundary conditions:
  - A request arriving while the other cache is served waits in ARB_IDLE selection; it is not dropped.
  - A requester dropping its request mid-transaction is illegal. The arbiter completes the latched transaction anyway and still pulses resp.
  - mem_resp in ARB_IDLE is ignored: no resp to either cache.
  - dcache_pmem_read and dcache_pmem_write both high is illegal. Write takes precedence; a simulation-only assertion flags it.
  - rst during a transaction returns the arbiter to ARB_IDLE next edge and drops mem_read/mem_write. The adaptor is reset by the same rst.
  - Address/wdata changes from a requester after grant are ignored.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin tie-break using a 1-bit last-owner register. On a simultaneous request, the cache not granted last time wins. The register updates on every grant.
- Undefined: fixed D-cache priority, with no pointer register.

Decomposition:
- Shared package (rv32i_types, or arb_types imported alongside it):
  - arb_state_t enum {ARB_IDLE, ARB_ICACHE, ARB_DCACHE}.
  - arb_owner_t enum {OWN_ICACHE, OWN_DCACHE}.
  - Line width and address width constants.
- Natural sub-module: cache_arb_select, a small combinational winner picker.
  - Inputs: i_req, d_req, last_owner.
  - Output: an arb_owner_t grant.
  - Contains the CACHE_ARB_RR_EN ifdef, so the FSM stays free of it.

Test Plan:
- I-cache read only, addr 0x0000_1000, memory model responds after 5 cycles:
  - mem_read=1 one cycle after the request, mem_address=0x0000_1000.
  - icache_pmem_resp pulses exactly once with model line 0xA5…A5.
  - dcache_pmem_resp never asserts.
- D-cache writeback, addr 0x0000_2040, wdata = 256'hDEAD…BEEF:
  - mem_write=1 with exact wdata/address held stable every cycle until mem_resp.
  - dcache_pmem_resp one cycle, then IDLE.
- Simultaneous I read 0x100 and D read 0x200, feature off:
  - D served first (mem_address=0x200), then I (0x100), with one IDLE cycle between.
  - Each resp targets the correct cache.
- Same simultaneous pair repeated three times with CACHE_ARB_RR_EN defined:
  - Grants alternate: D, I, D, I, D, I.
- rst asserted two cycles into a D read:
  - Next edge has mem_read=0 and state ARB_IDLE.
  - A stale mem_resp after that produces no cache resp.
- Requester changes address 0x300→0x340 mid-transaction:
  - mem_address stays 0x300 until resp.
